// File: rtl/riscv_pkg.sv
// Shared yarc core types: memory operations, trap causes, LSU FSM states and
// small decode helpers used by the load/store unit.
package riscv_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_oper_t;

  typedef enum logic [3:0] {
    NO_TRAP               = 4'd0,
    INSTR_ADDR_MISALIGNED = 4'd1,
    ILLEGAL_INSTR         = 4'd2,
    BREAKPOINT            = 4'd3,
    LOAD_ADDR_MISALIGNED  = 4'd4,
    STORE_ADDR_MISALIGNED = 4'd5,
    ECALL_M               = 4'd6
  } exc_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input mem_oper_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input mem_oper_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0.
  function automatic logic is_misaligned(input mem_oper_t op, input logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return (lo != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables and lane-replicated
// store data on the way out, byte/halfword extract and extend on the way in.
// Low address bits below natural alignment are ignored, so a halfword uses
// addr[1] only and a word uses neither bit.
module lsu_align
  import riscv_pkg::*;
(
  input  mem_oper_t   mem_oper_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  rdata_bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign rdata_bytes[gi] = rdata_i[8*gi +: 8];
  end

  // Byte enables by access size, and store data replicated across all lanes
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = store_data_i;
    case (mem_oper_i)
      MEM_LB, MEM_LBU, MEM_SB: be_o = 4'b0001 << addr_lo_i;
      MEM_LH, MEM_LHU, MEM_SH: be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
      MEM_LW, MEM_SW:          be_o = 4'b1111;
      default:                 be_o = 4'b0000;
    endcase
    case (mem_oper_i)
      MEM_SB:  wdata_o = {4{store_data_i[7:0]}};
      MEM_SH:  wdata_o = {2{store_data_i[15:0]}};
      default: wdata_o = store_data_i;
    endcase
  end

  // Select the addressed byte/halfword of the read word and extend it
  always_comb begin
    byte_sel = rdata_bytes[addr_lo_i];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (mem_oper_i)
      MEM_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data_o = {24'h000000, byte_sel};
      MEM_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: load_data_o = {16'h0000, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// yarc MEM stage: load/store unit on a req/gnt/rvalid data bus.
// One transaction outstanding at most; the pipeline is stalled while it runs.
// Optional build macro YARC_LSU_MISALIGN_TRAP_EN: when defined, misaligned
// halfword/word accesses trap instead of being issued with masked low bits.
module lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_oper2_i,
  input  mem_oper_t   mem_oper_i,
  input  logic        write_rd_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] pc_i,
  input  logic        instr_valid_i,
  input  exc_t        trap_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] rd_data_o,
  output logic        write_rd_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output exc_t        trap_o
);

  lsu_state_t  state_reg, state_next;
  logic        kill_reg, kill_next;
  logic [31:0] req_addr_reg;
  logic [31:0] req_wdata_reg;
  logic [3:0]  req_be_reg;
  logic        req_we_reg;
  logic [1:0]  req_lo_reg;
  mem_oper_t   req_oper_reg;

  mem_oper_t   align_oper;
  logic [1:0]  align_lo;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] load_data;

  logic        is_mem_op;
  logic        misalign;
  logic        access;
  logic        wb_bubble;
  logic [31:0] wb_data_next;
  logic        wb_write_rd_next;
  logic        wb_valid_next;
  exc_t        wb_trap_next;

  assign is_mem_op = is_load(mem_oper_i) | is_store(mem_oper_i);

`ifdef YARC_LSU_MISALIGN_TRAP_EN
  assign misalign = instr_valid_i & is_misaligned(mem_oper_i, alu_result_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // A live, untrapped, unflushed memory op starts a bus transaction
  assign access = instr_valid_i & is_mem_op & (trap_i == NO_TRAP) & ~flush_i & ~misalign;

  // Lane logic sees the incoming op in IDLE and the captured op afterwards
  always_comb begin
    align_oper = mem_oper_i;
    align_lo   = alu_result_i[1:0];
    if (state_reg != IDLE) begin
      align_oper = req_oper_reg;
      align_lo   = req_lo_reg;
    end
  end

  lsu_align u_align (
    .mem_oper_i   (align_oper),
    .addr_lo_i    (align_lo),
    .store_data_i (alu_oper2_i),
    .rdata_i      (dmem_rdata_i),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .load_data_o  (load_data)
  );

  // FSM next state, bus request and stall
  always_comb begin
    state_next   = state_reg;
    kill_next    = kill_reg;
    stall_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_be_o    = 4'b0000;
    dmem_addr_o  = req_addr_reg;
    dmem_wdata_o = req_wdata_reg;
    case (state_reg)
      IDLE: begin
        dmem_addr_o  = {alu_result_i[31:2], 2'b00};
        dmem_wdata_o = align_wdata;
        if (access) begin
          dmem_req_o = 1'b1;
          dmem_we_o  = is_store(mem_oper_i);
          dmem_be_o  = align_be;
          stall_o    = 1'b1;
          if (dmem_gnt_i) state_next = WAIT_RVALID;
          else            state_next = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = req_we_reg;
        dmem_be_o  = req_be_reg;
        stall_o    = 1'b1;
        if (flush_i)    kill_next  = 1'b1;
        if (dmem_gnt_i) state_next = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        stall_o = ~dmem_rvalid_i;
        if (flush_i) kill_next = 1'b1;
        if (dmem_rvalid_i) begin
          state_next = IDLE;
          kill_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and kill flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
      kill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
    end
  end

  // Capture the request on its first cycle so it stays stable until grant
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_addr_reg  <= 32'h0;
      req_wdata_reg <= 32'h0;
      req_be_reg    <= 4'b0000;
      req_we_reg    <= 1'b0;
      req_lo_reg    <= 2'b00;
      req_oper_reg  <= MEM_NOP;
    end else if (state_reg == IDLE && access) begin
      req_addr_reg  <= {alu_result_i[31:2], 2'b00};
      req_wdata_reg <= align_wdata;
      req_be_reg    <= align_be;
      req_we_reg    <= is_store(mem_oper_i);
      req_lo_reg    <= alu_result_i[1:0];
      req_oper_reg  <= mem_oper_i;
    end
  end

  // A flush now, or an earlier flush of the outstanding access, yields a bubble
  assign wb_bubble = flush_i | ((state_reg == WAIT_RVALID) & kill_reg);

  // MEM/WB next values: load result, misalignment trap, or pass-through
  always_comb begin
    wb_data_next     = alu_result_i;
    wb_write_rd_next = write_rd_i & ~is_store(mem_oper_i) & ~misalign;
    wb_valid_next    = instr_valid_i;
    wb_trap_next     = trap_i;
    if (state_reg == WAIT_RVALID && is_load(req_oper_reg)) wb_data_next = load_data;
    if (trap_i == NO_TRAP && misalign) begin
      if (is_load(mem_oper_i)) wb_trap_next = LOAD_ADDR_MISALIGNED;
      else                     wb_trap_next = STORE_ADDR_MISALIGNED;
    end
    if (wb_bubble) begin
      wb_write_rd_next = 1'b0;
      wb_valid_next    = 1'b0;
      wb_trap_next     = NO_TRAP;
    end
  end

  // MEM/WB pipeline registers advance whenever the stage is not stalled
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_data_o     <= 32'h0;
      write_rd_o    <= 1'b0;
      rd_addr_o     <= 5'd0;
      pc_o          <= 32'h0;
      instr_valid_o <= 1'b0;
      trap_o        <= NO_TRAP;
    end else if (!stall_o) begin
      rd_data_o     <= wb_data_next;
      write_rd_o    <= wb_write_rd_next;
      rd_addr_o     <= rd_addr_i;
      pc_o          <= pc_i;
      instr_valid_o <= wb_valid_next;
      trap_o        <= wb_trap_next;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single transactions with chosen
// grant/rvalid delays, plus hand-written flush and reset sequences.
module tb_lsu;
  import riscv_pkg::*;

  logic        clk;
  logic        rstn;
  logic [31:0] alu_result, alu_oper2;
  mem_oper_t   mem_oper;
  logic        write_rd;
  logic [4:0]  rd_addr;
  logic [31:0] pc;
  logic        instr_valid;
  exc_t        trap_in;
  logic        flush;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] rd_data;
  logic        write_rd_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  exc_t        trap_out;

  int checks = 0;
  int failures = 0;

  lsu dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .alu_result_i  (alu_result),
    .alu_oper2_i   (alu_oper2),
    .mem_oper_i    (mem_oper),
    .write_rd_i    (write_rd),
    .rd_addr_i     (rd_addr),
    .pc_i          (pc),
    .instr_valid_i (instr_valid),
    .trap_i        (trap_in),
    .flush_i       (flush),
    .stall_o       (stall),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_be_o     (dmem_be),
    .dmem_addr_o   (dmem_addr),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_gnt_i    (dmem_gnt),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata),
    .rd_data_o     (rd_data),
    .write_rd_o    (write_rd_out),
    .rd_addr_o     (rd_addr_out),
    .pc_o          (pc_out),
    .instr_valid_o (instr_valid_out),
    .trap_o        (trap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mem_oper_t   op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        wr;
    exc_t        trap_in;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_baddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic        exp_wr;
    exc_t        exp_trap;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input mem_oper_t op, input logic [31:0] addr, input logic [31:0] rs2,
                              input logic wr, input exc_t tin, input int gd, input int rvd,
                              input logic [31:0] rdata, input logic ereq, input logic ewe,
                              input logic [3:0] ebe, input logic [31:0] ebaddr,
                              input logic [31:0] ewdata, input logic [31:0] erd,
                              input logic ewr, input exc_t etrap);
    vec_t v;
    v.op = op; v.addr = addr; v.rs2 = rs2; v.wr = wr; v.trap_in = tin;
    v.gnt_dly = gd; v.rv_dly = rvd; v.rdata = rdata;
    v.exp_req = ereq; v.exp_we = ewe; v.exp_be = ebe; v.exp_baddr = ebaddr;
    v.exp_wdata = ewdata; v.exp_rd = erd; v.exp_wr = ewr; v.exp_trap = etrap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input mem_oper_t op, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic wr, input logic [4:0] rd, input logic [31:0] pcv,
                       input exc_t tin, input logic valid, input logic fl);
    mem_oper = op; alu_result = addr; alu_oper2 = rs2; write_rd = wr; rd_addr = rd;
    pc = pcv; trap_in = tin; instr_valid = valid; flush = fl;
  endtask

  // Runs one table vector; entered and left at 1 time unit after a rising edge.
  task automatic run_vec(input int idx);
    vec_t v;
    logic [31:0] pcv;
    logic [4:0]  rdv;
    v   = vecs[idx];
    pcv = 32'h1000 + 32'(idx * 4);
    rdv = 5'(idx + 1);
    drive(v.op, v.addr, v.rs2, v.wr, rdv, pcv, v.trap_in, 1'b1, 1'b0);
    if (!v.exp_req) begin
      dmem_gnt = 1'b0;
      #1;
      chk($sformatf("v%0d_nobus", idx), 128'({dmem_req, dmem_we, dmem_be, stall}), 128'(7'd0));
      @(posedge clk); #1;
    end else begin
      for (int g = 0; g <= v.gnt_dly; g++) begin
        dmem_gnt = (g == v.gnt_dly);
        #1;
        chk($sformatf("v%0d_req_c%0d", idx, g), 128'({dmem_req, dmem_we, dmem_addr, stall}),
            128'({1'b1, v.exp_we, v.exp_baddr, 1'b1}));
        if (v.exp_we)
          chk($sformatf("v%0d_lanes_c%0d", idx, g), 128'({dmem_be, dmem_wdata}),
              128'({v.exp_be, v.exp_wdata}));
        @(posedge clk); #1;
      end
      dmem_gnt = 1'b0;
      for (int r = 0; r <= v.rv_dly; r++) begin
        dmem_rvalid = (r == v.rv_dly);
        dmem_rdata  = dmem_rvalid ? v.rdata : 32'h0;
        #1;
        chk($sformatf("v%0d_wait_c%0d", idx, r), 128'({dmem_req, stall}),
            128'({1'b0, (r != v.rv_dly)}));
        @(posedge clk); #1;
      end
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
    end
    chk($sformatf("v%0d_memwb", idx),
        128'({rd_data, write_rd_out, rd_addr_out, pc_out, instr_valid_out, trap_out}),
        128'({v.exp_rd, v.exp_wr, rdv, pcv, 1'b1, v.exp_trap}));
    $display("vec %0d op=%s addr=%08h rd_data=%08h write_rd=%0b trap=%s",
             idx, v.op.name(), v.addr, rd_data, write_rd_out, trap_out.name());
  endtask

  initial begin
    // op      addr         rs2          wr  trap     gd rvd rdata        req we be     baddr        wdata        rd_data      wr  trap
    vecs[0]  = mk(MEM_LW,  32'h100, 32'h0,        1, NO_TRAP, 0, 0, 32'hDEADBEEF, 1, 0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF, 1, NO_TRAP);
    vecs[1]  = mk(MEM_LB,  32'h103, 32'h0,        1, NO_TRAP, 0, 0, 32'h80FFFF7F, 1, 0, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80, 1, NO_TRAP);
    vecs[2]  = mk(MEM_LBU, 32'h103, 32'h0,        1, NO_TRAP, 0, 0, 32'h80FFFF7F, 1, 0, 4'h8, 32'h100, 32'h0,        32'h00000080, 1, NO_TRAP);
    vecs[3]  = mk(MEM_LH,  32'h102, 32'h0,        1, NO_TRAP, 0, 0, 32'h80017FFF, 1, 0, 4'hC, 32'h100, 32'h0,        32'hFFFF8001, 1, NO_TRAP);
    vecs[4]  = mk(MEM_LHU, 32'h100, 32'h0,        1, NO_TRAP, 0, 0, 32'h1234F00D, 1, 0, 4'h3, 32'h100, 32'h0,        32'h0000F00D, 1, NO_TRAP);
    vecs[5]  = mk(MEM_LB,  32'h101, 32'h0,        1, NO_TRAP, 1, 2, 32'h00007F00, 1, 0, 4'h2, 32'h100, 32'h0,        32'h0000007F, 1, NO_TRAP);
    vecs[6]  = mk(MEM_SH,  32'h202, 32'h1234ABCD, 1, NO_TRAP, 3, 0, 32'h0,        1, 1, 4'hC, 32'h200, 32'hABCDABCD, 32'h00000202, 0, NO_TRAP);
    vecs[7]  = mk(MEM_SB,  32'h301, 32'h000000A5, 0, NO_TRAP, 0, 1, 32'h0,        1, 1, 4'h2, 32'h300, 32'hA5A5A5A5, 32'h00000301, 0, NO_TRAP);
    vecs[8]  = mk(MEM_SW,  32'h400, 32'hCAFEF00D, 0, NO_TRAP, 2, 1, 32'h0,        1, 1, 4'hF, 32'h400, 32'hCAFEF00D, 32'h00000400, 0, NO_TRAP);
    vecs[9]  = mk(MEM_NOP, 32'h55,  32'h0,        1, NO_TRAP, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        32'h00000055, 1, NO_TRAP);
    vecs[10] = mk(MEM_NOP, 32'h0,   32'h0,        0, NO_TRAP, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        32'h00000000, 0, NO_TRAP);
    vecs[11] = mk(MEM_LW,  32'h100, 32'h0,        0, ILLEGAL_INSTR, 0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        32'h00000100, 0, ILLEGAL_INSTR);
`ifdef YARC_LSU_MISALIGN_TRAP_EN
    vecs[12] = mk(MEM_LW,  32'h101, 32'h0,        1, NO_TRAP, 0, 0, 32'h76543210, 0, 0, 4'h0, 32'h0,   32'h0,        32'h00000101, 0, LOAD_ADDR_MISALIGNED);
    vecs[13] = mk(MEM_SH,  32'h203, 32'h0000BEEF, 0, NO_TRAP, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        32'h00000203, 0, STORE_ADDR_MISALIGNED);
`else
    vecs[12] = mk(MEM_LW,  32'h101, 32'h0,        1, NO_TRAP, 0, 0, 32'h76543210, 1, 0, 4'hF, 32'h100, 32'h0,        32'h76543210, 1, NO_TRAP);
    vecs[13] = mk(MEM_SH,  32'h203, 32'h0000BEEF, 0, NO_TRAP, 0, 0, 32'h0,        1, 1, 4'hC, 32'h200, 32'hBEEFBEEF, 32'h00000203, 0, NO_TRAP);
`endif
    vecs[14] = mk(MEM_LBU, 32'h102, 32'h0,        1, NO_TRAP, 0, 3, 32'h00AB0000, 1, 0, 4'h4, 32'h100, 32'h0,        32'h000000AB, 1, NO_TRAP);

    rstn = 1'b0;
    drive(MEM_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, NO_TRAP, 1'b0, 1'b0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus", 128'({dmem_req, dmem_we, dmem_be, stall}), 128'(7'd0));
    chk("reset_memwb", 128'({rd_data, write_rd_out, rd_addr_out, pc_out, instr_valid_out, trap_out}),
        128'({32'h0, 1'b0, 5'd0, 32'h0, 1'b0, NO_TRAP}));
    $display("reset done");
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(i);

    // Flush while waiting for rvalid: stall holds until rvalid, result discarded
    drive(MEM_LW, 32'h100, 32'h0, 1'b1, 5'd9, 32'h2000, NO_TRAP, 1'b1, 1'b0);
    dmem_gnt = 1'b1;
    #1; chk("flrv_req", 128'({dmem_req, stall}), 128'(2'b11));
    @(posedge clk); #1;
    dmem_gnt = 1'b0; flush = 1'b1;
    #1; chk("flrv_stall_flush", 128'({dmem_req, stall}), 128'(2'b01));
    @(posedge clk); #1;
    flush = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    #1; chk("flrv_stall_rvalid", 128'(stall), 128'(1'b0));
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    chk("flrv_bubble", 128'({write_rd_out, instr_valid_out, trap_out}), 128'({1'b0, 1'b0, NO_TRAP}));
    $display("seq flush_wait_rvalid write_rd=%0b instr_valid=%0b", write_rd_out, instr_valid_out);

    // Following ALU op flows normally after the killed load
    drive(MEM_NOP, 32'h77, 32'h0, 1'b1, 5'd3, 32'h2004, NO_TRAP, 1'b1, 1'b0);
    #1; chk("post_kill_nostall", 128'({dmem_req, stall}), 128'(2'b00));
    @(posedge clk); #1;
    chk("post_kill_memwb", 128'({rd_data, write_rd_out, instr_valid_out}), 128'({32'h77, 1'b1, 1'b1}));
    $display("seq post_kill rd_data=%08h", rd_data);

    // Flush in IDLE on a load: no bus access, bubble into MEM/WB
    drive(MEM_LW, 32'h180, 32'h0, 1'b1, 5'd4, 32'h2008, NO_TRAP, 1'b1, 1'b1);
    #1; chk("flidle_nobus", 128'({dmem_req, stall}), 128'(2'b00));
    @(posedge clk); #1;
    chk("flidle_bubble", 128'({write_rd_out, instr_valid_out, trap_out}), 128'({1'b0, 1'b0, NO_TRAP}));
    $display("seq flush_idle write_rd=%0b instr_valid=%0b", write_rd_out, instr_valid_out);

    // Flush while waiting for grant: request held, result discarded
    drive(MEM_LW, 32'h1C0, 32'h0, 1'b1, 5'd6, 32'h200C, NO_TRAP, 1'b1, 1'b0);
    dmem_gnt = 1'b0;
    #1; chk("flgnt_req0", 128'({dmem_req, dmem_addr, stall}), 128'({1'b1, 32'h1C0, 1'b1}));
    @(posedge clk); #1;
    flush = 1'b1;
    #1; chk("flgnt_req1", 128'({dmem_req, dmem_addr, stall}), 128'({1'b1, 32'h1C0, 1'b1}));
    @(posedge clk); #1;
    flush = 1'b0; dmem_gnt = 1'b1;
    #1; chk("flgnt_req2", 128'({dmem_req, stall}), 128'(2'b11));
    @(posedge clk); #1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA5555;
    #1; chk("flgnt_rvalid", 128'({dmem_req, stall}), 128'(2'b00));
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    chk("flgnt_bubble", 128'({write_rd_out, instr_valid_out}), 128'(2'b00));
    $display("seq flush_wait_gnt write_rd=%0b instr_valid=%0b", write_rd_out, instr_valid_out);

    // Reset in the middle of a transaction drops the request at once
    drive(MEM_SW, 32'h240, 32'h11223344, 1'b0, 5'd0, 32'h2010, NO_TRAP, 1'b1, 1'b0);
    dmem_gnt = 1'b0;
    #1; chk("rst_mid_req", 128'({dmem_req, dmem_we, stall}), 128'(3'b111));
    @(posedge clk); #1;
    drive(MEM_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, NO_TRAP, 1'b0, 1'b0);
    rstn = 1'b0;
    #1; chk("rst_mid_bus", 128'({dmem_req, dmem_we, dmem_be, stall}), 128'(7'd0));
    chk("rst_mid_memwb", 128'({rd_data, write_rd_out, pc_out, instr_valid_out, trap_out}),
        128'({32'h0, 1'b0, 32'h0, 1'b0, NO_TRAP}));
    $display("seq reset_mid req=%0b stall=%0b", dmem_req, stall);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_idle", 128'({dmem_req, stall}), 128'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
